// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and defaults for the eth transmit scheduler
package eth_pkg;

   typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, SEND, GAP} eth_sched_state_t;

   localparam int ETH_IFG_CYCLES = 12;
   localparam int ETH_START_WAIT = 16;
   localparam int ETH_TX_TIMEOUT = 2048;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/eth_tx_sched_if.sv
// rtl/eth_tx_sched_if.sv - requester/sender handshake bundle of the transmit scheduler
interface eth_tx_sched_if #(
   parameter int N_REQ = 2
);
   localparam int IW = $clog2(N_REQ);

   logic [N_REQ-1:0] i_req;
   logic [N_REQ-1:0] o_grant;
   logic [IW-1:0]    o_sel;
   logic             o_tx_start;
   logic             i_tx_busy;
   logic [N_REQ-1:0] o_done;
   logic             o_timeout;
   logic             o_busy;

   // master: the scheduler itself; slave: requesters plus the frame sender
   modport master (
      input  i_req, i_tx_busy,
      output o_grant, o_sel, o_tx_start, o_done, o_timeout, o_busy
   );

   modport slave (
      output i_req, i_tx_busy,
      input  o_grant, o_sel, o_tx_start, o_done, o_timeout, o_busy
   );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, searches upward from ptr with wrap
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!valid && req[(int'(ptr) + i) % N]) begin
            valid                      = 1'b1;
            grant[(int'(ptr) + i) % N] = 1'b1;
            idx                        = IW'((int'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - round-robin owner of the single eth_send engine with gap and abort timers
module eth_tx_sched
   import eth_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter int IFG_CYCLES = ETH_IFG_CYCLES,
   parameter int START_WAIT = ETH_START_WAIT,
   parameter int TIMEOUT    = ETH_TX_TIMEOUT
) (
   input  logic          clk,
   input  logic          rst_n,
   eth_tx_sched_if.master bus
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(max3(TIMEOUT, START_WAIT, IFG_CYCLES) + 1);

   eth_sched_state_t state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [IW-1:0]    ptr;
   logic [N_REQ-1:0] grant_q;
   logic [IW-1:0]    sel_q;
   logic [N_REQ-1:0] done_q;
   logic             to_q;

   logic [N_REQ-1:0] pick_grant;
   logic [IW-1:0]    pick_idx;
   logic             pick_valid;
   logic             load, done_set, to_set;

   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req   (bus.i_req),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load      = 1'b0;
      done_set  = 1'b0;
      to_set    = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               load      = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            state_nxt = WAIT_BUSY;
            cnt_nxt   = '0;
         end
         WAIT_BUSY: begin
            if (bus.i_tx_busy) begin
               state_nxt = SEND;
               cnt_nxt   = '0;
            end else if (cnt == CW'(START_WAIT - 1)) begin
               to_set    = 1'b1;
               state_nxt = GAP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         SEND: begin
            // a falling busy on the timeout boundary still counts as a clean finish
            if (!bus.i_tx_busy) begin
               done_set  = 1'b1;
               state_nxt = GAP;
               cnt_nxt   = '0;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               to_set    = 1'b1;
               state_nxt = GAP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         GAP: begin
            if (cnt == CW'(IFG_CYCLES - 1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         ptr     <= '0;
         grant_q <= '0;
         sel_q   <= '0;
         done_q  <= '0;
         to_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         done_q <= done_set ? grant_q : '0;
         to_q   <= to_set;
         if (load) begin
            grant_q <= pick_grant;
            sel_q   <= pick_idx;
            ptr     <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
         end else if (done_set || to_set) begin
            grant_q <= '0;
         end
      end
   end

   assign bus.o_grant    = grant_q;
   assign bus.o_sel      = sel_q;
   assign bus.o_tx_start = (state == START);
   assign bus.o_done     = done_q;
   assign bus.o_timeout  = to_q;
   assign bus.o_busy     = (state != IDLE);

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb/tb_eth_tx_sched.sv - scoreboard bench for eth_tx_sched
module tb_eth_tx_sched;
   import eth_pkg::*;

   localparam int N_REQ      = 2;
   localparam int IFG_CYCLES = 12;
   localparam int START_WAIT = 16;
   localparam int TIMEOUT    = 2048;

   typedef struct {
      int idx;
      bit is_to;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   n_start;
   exp_t exp_q[$];

   eth_tx_sched_if #(.N_REQ(N_REQ)) bus ();

   eth_tx_sched #(
      .N_REQ      (N_REQ),
      .IFG_CYCLES (IFG_CYCLES),
      .START_WAIT (START_WAIT),
      .TIMEOUT    (TIMEOUT)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input int idx, input bit is_to);
      exp_t e;
      e.idx   = idx;
      e.is_to = is_to;
      exp_q.push_back(e);
   endtask

   task automatic wait_start(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick();
         ok = bus.o_tx_start;
      end
      check(tag, 32'(ok), 1);
   endtask

   task automatic wait_end(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         ok = (bus.o_done != '0) || bus.o_timeout;
      end
      check(tag, 32'(ok), 1);
   endtask

   task automatic wait_idle(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick();
         ok = !bus.o_busy;
      end
      check(tag, 32'(ok), 1);
   endtask

   task automatic send(input int dly, input int len);
      repeat (dly) tick();
      bus.i_tx_busy = 1'b1;
      repeat (len) tick();
      bus.i_tx_busy = 1'b0;
   endtask

   // scoreboard side: every done/timeout pulse retires one expected frame outcome
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_tx_start) n_start++;
         if (bus.o_done != '0 || bus.o_timeout) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected", 32'(bus.o_sel), 32'hffff_ffff);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_owner", 32'(bus.o_sel), 32'(e.idx));
               check("sb_timeout", 32'(bus.o_timeout), 32'(e.is_to));
               check("sb_done", 32'(bus.o_done), e.is_to ? 32'd0 : (32'd1 << e.idx));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int starts_before;
      int grants_seen;
      n_checks      = 0;
      n_fail        = 0;
      n_start       = 0;
      rst_n         = 1'b0;
      bus.i_req     = '0;
      bus.i_tx_busy = 1'b0;
      repeat (3) tick();
      check("rst_grant", 32'(bus.o_grant), 0);
      check("rst_sel", 32'(bus.o_sel), 0);
      check("rst_start", 32'(bus.o_tx_start), 0);
      check("rst_done", 32'(bus.o_done), 0);
      check("rst_timeout", 32'(bus.o_timeout), 0);
      check("rst_busy", 32'(bus.o_busy), 0);
      rst_n = 1'b1;
      tick();

      // 1: single frame, grant and start on the cycle after the request edge
      push(0, 1'b0);
      bus.i_req = 2'b01;
      tick();
      check("t1_grant", 32'(bus.o_grant), 32'b01);
      check("t1_sel", 32'(bus.o_sel), 0);
      check("t1_start", 32'(bus.o_tx_start), 1);
      tick();
      check("t1_start_once", 32'(bus.o_tx_start), 0);
      send(1, 64);
      tick();
      check("t1_done", 32'(bus.o_done), 32'b01);
      check("t1_grant_rel", 32'(bus.o_grant), 0);
      bus.i_req = '0;
      repeat (IFG_CYCLES - 1) tick();
      check("t1_gap_busy", 32'(bus.o_busy), 1);
      tick();
      check("t1_idle", 32'(bus.o_busy), 0);
      check("t1_nstart", 32'(n_start), 1);

      // 2: both requesting from reset, order 0,1,0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      push(0, 1'b0);
      push(1, 1'b0);
      push(0, 1'b0);
      bus.i_req = 2'b11;
      for (int f = 0; f < 3; f++) begin
         wait_start("t2_start");
         check("t2_sel", 32'(bus.o_sel), 32'(f % 2));
         send(2, 8);
         wait_end("t2_end");
      end
      bus.i_req = '0;
      wait_idle("t2_idle");

      // 3: busy never rises
      push(1, 1'b1);
      bus.i_req = 2'b10;
      wait_start("t3_start");
      n = 0;
      while (!bus.o_timeout && n < 100) begin
         tick();
         n++;
      end
      check("t3_wait", 32'(n - 1), START_WAIT);
      check("t3_nodone", 32'(bus.o_done), 0);
      check("t3_grant", 32'(bus.o_grant), 0);
      bus.i_req = '0;
      wait_idle("t3_idle");

      // 4: busy stuck high, then the other requester is served after the gap
      push(0, 1'b1);
      push(1, 1'b0);
      bus.i_req = 2'b01;
      wait_start("t4_start");
      repeat (2) tick();
      bus.i_tx_busy = 1'b1;
      bus.i_req     = 2'b11;
      n = 0;
      while (!bus.o_timeout && n < TIMEOUT + 100) begin
         tick();
         n++;
      end
      check("t4_send_len", 32'(n - 1), TIMEOUT);
      check("t4_grant", 32'(bus.o_grant), 0);
      bus.i_tx_busy = 1'b0;
      bus.i_req     = 2'b10;
      n = 0;
      while (bus.o_grant == '0 && n < 100) begin
         tick();
         n++;
      end
      check("t4_regrant", 32'(n), IFG_CYCLES + 1);
      check("t4_sel", 32'(bus.o_sel), 1);
      send(2, 4);
      wait_end("t4_end");
      bus.i_req = '0;
      wait_idle("t4_idle");

      // 5: reset in SEND; pointer back to 0 after release
      bus.i_req = 2'b01;
      wait_start("t5_start");
      repeat (2) tick();
      bus.i_tx_busy = 1'b1;
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      check("t5_rst_grant", 32'(bus.o_grant), 0);
      check("t5_rst_busy", 32'(bus.o_busy), 0);
      bus.i_tx_busy = 1'b0;
      bus.i_req     = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      push(0, 1'b0);
      bus.i_req = 2'b11;
      wait_start("t5_start2");
      check("t5_sel", 32'(bus.o_sel), 0);
      send(2, 6);
      wait_end("t5_end");
      bus.i_req = '0;
      wait_idle("t5_idle");

      // 6: short request pulse inside the gap is never granted
      push(1, 1'b0);
      bus.i_req = 2'b10;
      wait_start("t6_start");
      send(2, 5);
      wait_end("t6_end");
      bus.i_req = '0;
      repeat (2) tick();
      bus.i_req = 2'b01;
      repeat (3) tick();
      bus.i_req     = '0;
      starts_before = n_start;
      grants_seen   = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.o_grant != '0) grants_seen++;
      end
      check("t6_nogrant", 32'(grants_seen), 0);
      check("t6_nostart", 32'(n_start - starts_before), 0);
      check("t6_idle", 32'(bus.o_busy), 0);

      repeat (2) tick();
      check("sb_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
